// File: rtl/bshift_pkg.sv
// Shared widths, direction codes and bit-reverse helper for the barrel rotator.
// Latency: n/a (constants and a combinational function only).
// Backpressure: n/a.
package bshift_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    localparam logic ROT_RIGHT = 1'b0;
    localparam logic ROT_LEFT  = 1'b1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [AMT_W-1:0]  amt_t;

    function automatic data_t bitrev(input data_t d);
        data_t r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_rotator8_if.sv
// Operand/amount/direction bus into the rotator and the registered result back.
// Latency: n/a (wiring only).
// Backpressure: none; the bus carries no handshake.
interface barrel_rotator8_if;
    import bshift_pkg::*;

    data_t a;
    amt_t  amt;
    logic  lr;
    data_t y;

    modport master (
        output a,
        output amt,
        output lr,
        input  y
    );

    modport slave (
        input  a,
        input  amt,
        input  lr,
        output y
    );

endinterface

// File: rtl/rotr8_core.sv
// Combinational 8-bit right rotator built from three log stages (1, 2, 4).
// Latency: 0 cycles.
// Backpressure: none.
module rotr8_core
    import bshift_pkg::*;
(
    input  data_t data,
    input  amt_t  amt,
    output data_t data_out
);

    data_t s1;
    data_t s2;
    data_t s4;

    // Each stage moves bit i+2^k down into bit i, wrapping the low bits to the top.
    always_comb begin
        s1 = amt[0] ? {data[0],   data[7:1]} : data;
        s2 = amt[1] ? {s1[1:0],   s1[7:2]}   : s1;
        s4 = amt[2] ? {s2[3:0],   s2[7:4]}   : s2;
    end

    assign data_out = s4;

endmodule

// File: rtl/barrel_rotator8.sv
// Registered 8-bit rotate left/right by 0-7; left reuses the right core via bit reversal.
// Latency: 1 cycle, one new operation every cycle.
// Backpressure: none; inputs are sampled unconditionally each rising edge.
module barrel_rotator8
    import bshift_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    barrel_rotator8_if.slave     bus
);

    data_t pre;
    data_t core_out;
    data_t post;
    data_t y_q;

    // A left rotate is a right rotate of the mirrored operand, mirrored back.
    always_comb begin
        pre = (bus.lr == ROT_LEFT) ? bitrev(bus.a) : bus.a;
    end

    rotr8_core u_core (
        .data     (pre),
        .amt      (bus.amt),
        .data_out (core_out)
    );

    always_comb begin
        post = (bus.lr == ROT_LEFT) ? bitrev(core_out) : core_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= post;
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_barrel_rotator8.sv
// Directed bench for barrel_rotator8: reset, sweeps, equivalence, back-to-back, mid-stream reset.
module tb_barrel_rotator8;
    import bshift_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    barrel_rotator8_if bus ();

    barrel_rotator8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the capturing edge.
    task automatic step(input logic [7:0] a_v, input logic [2:0] amt_v, input logic lr_v);
        @(negedge clk);
        bus.a   = a_v;
        bus.amt = amt_v;
        bus.lr  = lr_v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_rotr(input logic [7:0] d, input int n);
        logic [15:0] dd;
        dd = {d, d} >> n;
        return dd[7:0];
    endfunction

    logic [7:0] right_exp [8];
    logic [7:0] left_exp  [8];
    logic [7:0] ra;
    logic [7:0] yr;
    logic [7:0] yl;

    initial begin
        checks   = 0;
        failures = 0;
        right_exp = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81, 8'hC0};
        left_exp  = '{8'h60, 8'hC0, 8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30};

        // Reset asserted from time zero
        reset   = 1'b1;
        bus.a   = 8'hFF;
        bus.amt = 3'd3;
        bus.lr  = ROT_RIGHT;
        #1;
        check("reset_immediate", bus.y, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", bus.y, 8'h00);

        // Deassert between edges; first update on the next edge
        @(negedge clk);
        bus.a   = 8'h60;
        bus.amt = 3'd1;
        bus.lr  = ROT_RIGHT;
        #1;
        reset = 1'b0;
        #1;
        check("reset_release_hold", bus.y, 8'h00);
        @(posedge clk);
        #1;
        check("first_after_reset", bus.y, 8'h30);

        for (int n = 0; n < 8; n++) begin
            step(8'h60, 3'(n), ROT_RIGHT);
            check($sformatf("right_sweep_%0d", n), bus.y, right_exp[n]);
        end

        for (int n = 0; n < 8; n++) begin
            step(8'h60, 3'(n), ROT_LEFT);
            check($sformatf("left_sweep_%0d", n), bus.y, left_exp[n]);
        end

        // Extra directed patterns, amt=0 identity both ways
        step(8'hA5, 3'd0, ROT_LEFT);
        check("ident_left", bus.y, 8'hA5);
        step(8'h3C, 3'd0, ROT_RIGHT);
        check("ident_right", bus.y, 8'h3C);
        step(8'h81, 3'd4, ROT_LEFT);
        check("left4_81", bus.y, 8'h18);
        step(8'hB1, 3'd3, ROT_RIGHT);
        check("right3_b1", bus.y, 8'h36);

        // Right by n must equal left by (8-n) mod 8, match the model and keep popcount
        for (int r = 0; r < 4; r++) begin
            ra = 8'($urandom_range(0, 255));
            for (int n = 0; n < 8; n++) begin
                step(ra, 3'(n), ROT_RIGHT);
                yr = bus.y;
                step(ra, 3'((8 - n) % 8), ROT_LEFT);
                yl = bus.y;
                check($sformatf("equiv_a%02h_n%0d", ra, n), yl, yr);
                check($sformatf("model_a%02h_n%0d", ra, n), yr, ref_rotr(ra, n));
                check($sformatf("popcnt_a%02h_n%0d", ra, n), 8'($countones(yl)), 8'($countones(ra)));
            end
        end

        // Back-to-back: new operands every cycle, no bubbles
        step(8'h01, 3'd7, ROT_LEFT);
        check("b2b_first", bus.y, 8'h80);
        bus.a   = 8'h80;
        bus.amt = 3'd7;
        bus.lr  = ROT_RIGHT;
        @(posedge clk);
        #1;
        check("b2b_second", bus.y, 8'h01);
        bus.a   = 8'hC3;
        bus.amt = 3'd2;
        bus.lr  = ROT_LEFT;
        @(posedge clk);
        #1;
        check("b2b_third", bus.y, 8'h0F);

        // Mid-stream reset pulse between edges during a right sweep
        step(8'h60, 3'd2, ROT_RIGHT);
        check("mid_before", bus.y, 8'h18);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_immediate", bus.y, 8'h00);
        #1;
        reset = 1'b0;
        #1;
        check("mid_reset_hold", bus.y, 8'h00);
        step(8'h60, 3'd3, ROT_RIGHT);
        check("mid_resume", bus.y, 8'h0C);
        step(8'h60, 3'd6, ROT_RIGHT);
        check("mid_resume2", bus.y, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
